vc_arbiter: RTL
===============

# vc_arbiter

Weighted round-robin scheduler for the VC0/VC1 → D0/D1 stage of the switch datapath. It generates `pop_vc0`/`pop_vc1` for the two virtual-channel FIFOs and honours per-destination backpressure from the D0/D1 FIFOs. It emits the registered select, valid and destination strobes that steer the VC mux and the D demux. It replaces the free-running pop logic with a credit-based, work-conserving arbiter gated by the main FSM's active state.

## Interface
- `DATA_SIZE`, 6: word width; destination bit is `DATA_SIZE-2`.
- `WEIGHT0`, 3: consecutive grants VC0 may take per round; legal range 1..2^CNT_W-1.
- `WEIGHT1`, 1: consecutive grants VC1 may take per round; same range.
- `CNT_W`, 3: credit counter width.
- `clk` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `active` in 1: active state from the main FSM; arbitration is enabled only while it is 1.
- `empty_vc0`, `empty_vc1` in 1: VC FIFO empty flags.
- `dest_vc0`, `dest_vc1` in 1: destination bit of each VC FIFO head word; 0 selects D0, 1 selects D1.
- `pause_d0`, `pause_d1` in 1: D FIFO almost-full pause flags.
- `pop_vc0`, `pop_vc1` out 1: VC FIFO pops; combinational, at most one high per cycle.
- `valid_out` out 1: registered; a word leaves the mux this cycle.
- `sel_vc` out 1: registered; the VC popped last cycle, used as the mux select.
- `dest_out` out 1: registered; destination of that word, driving the D demux push.
- `credit` out CNT_W: registered credit count of the currently served VC.

## Operation
- Eligibility:
  - `el0 = active & ~empty_vc0 & ~(dest_vc0 ? pause_d1 : pause_d0)`.
  - `el1` is defined the same way with the VC1 signals.
- States:
  - IDLE: no pops.
  - SERVE0 / SERVE1: the preferred VC is 0 / 1.
- IDLE: while `active`=1, go to SERVE0 with credit 0 and no pop that cycle (one bubble). Otherwise stay in IDLE.
- SERVEk, in priority order:
  - If `elk`, grant VCk.
  - Else if the other VC is eligible, grant the other VC; the fallback grant restarts its credit at 0 before incrementing.
  - Else, no grant; state and credit are held.
- After granting VCj with new credit c = old credit + 1:
  - If c == WEIGHTj, the next state is SERVE(other j) with credit 0.
  - Otherwise, the next state is SERVEj with credit c.
- `active`=0 in any SERVE state:
  - Pops are 0 in that same cycle.
  - Next state is IDLE with credit 0.
- Registered outputs, updated every clock:
  - `valid_out` = pop_vc0|pop_vc1.
  - `sel_vc` = pop_vc1.
  - `dest_out` = destination bit of the popped VC.
  - When no pop occurs, `sel_vc` and `dest_out` hold their values.
- The arbiter is work-conserving: it never idles while either VC is eligible in a SERVE state.

## Timing
- Reset values: state IDLE, `credit`=0, `valid_out`=0, `sel_vc`=0, `dest_out`=0.
- Pops are forced to 0 combinationally while `reset`=1.
- Pop latency: 0 cycles from eligibility. Pops are a Mealy function of the registered state and the current flags.
- `valid_out`/`sel_vc`/`dest_out` lag the pop by exactly 1 cycle, aligned with the VC FIFO's registered read data.
- Pause change: if `pause_dX` rises in cycle n, any head word targeting X is not popped in cycle n. A word already popped in n-1 is still pushed; D FIFO almost-full slack absorbs it.
- Empty race: the pop for a VC is 0 in any cycle where its `empty` flag is 1; no pop is ever issued to an empty FIFO.
- Reset mid-operation: immediate clear; a word popped in the reset-assert cycle produces no `valid_out`.
- Credit never exceeds WEIGHTj-1 in the registered state.

## Structure
- The shared package `switch_pkg` holds:
  - State encodings: ST_IDLE=2'b00, ST_SERVE0=2'b01, ST_SERVE1=2'b10.
  - The DEST_BIT index constant.
- One sub-module, `wrr_credit`: credit counter with load-zero, increment and terminal-count (== weight) output, instantiated once with its weight muxed by the served VC.
- Everything else is flat in `vc_arbiter`.

## Test plan
- Reset mid-burst: `reset`=1 while `pop_vc0`=1 → pops 0 the same cycle; next edge gives state IDLE, `valid_out`=0, `credit`=0.
- Both VCs full, no pause, `active`=1, weights 3/1 → one bubble, then the pop pattern 0,0,0,1 repeats. `valid_out`=1 continuously from the second pop cycle, and `sel_vc` follows the pattern delayed by 1.
- VC0 head dest=1 with `pause_d1`=1; VC1 head dest=0 → VC1 popped every cycle, VC0 never; `dest_out`=0.
- `empty_vc1`=1 throughout, VC0 loaded with 5 words → 5 consecutive `pop_vc0`; credit cycles 1,2,0,1,2.
- `active` drops to 0 mid-stream → pops 0 that cycle, IDLE next. On `active`=1, one bubble cycle, then resume at SERVE0 with credit 0.
- `pause_d0`=`pause_d1`=1 with both VCs loaded → no pops, and `credit`/state hold for 10 cycles. On release, the grant resumes from the held state.

Source files
------------

// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared state encodings and datapath constants for the switch
package switch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SERVE0 = 2'b01,
        ST_SERVE1 = 2'b10
    } arb_state_e;

    localparam int DATA_SIZE_DEF = 6;
    // Destination lives just below the MSB of each queued word.
    localparam int DEST_BIT      = DATA_SIZE_DEF - 2;

endpackage

// File: rtl/wrr_credit.sv
// rtl/wrr_credit.sv - weighted round-robin credit counter with terminal-count flag
module wrr_credit #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic             restart_i,
    input  logic [CNT_W-1:0] weight_i,
    output logic [CNT_W-1:0] credit_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] credit_q;
    logic [CNT_W-1:0] credit_d;
    logic [CNT_W-1:0] cnt_inc;

    // A fallback grant counts from zero rather than the other VC's credit.
    assign cnt_inc  = (restart_i ? '0 : credit_q) + CNT_W'(1);
    assign tc_o     = inc_i & (cnt_inc == weight_i);
    assign credit_o = credit_q;

    always_comb begin
        credit_d = credit_q;
        if (clr_i || tc_o) begin
            credit_d = '0;
        end else if (inc_i) begin
            credit_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

endmodule

// File: rtl/vc_arbiter.sv
// rtl/vc_arbiter.sv - credit-based work-conserving VC0/VC1 to D0/D1 arbiter
module vc_arbiter
    import switch_pkg::*;
#(
    parameter int DATA_SIZE = 6,
    parameter int WEIGHT0   = 3,
    parameter int WEIGHT1   = 1,
    parameter int CNT_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             active,
    input  logic             empty_vc0,
    input  logic             empty_vc1,
    input  logic             dest_vc0,
    input  logic             dest_vc1,
    input  logic             pause_d0,
    input  logic             pause_d1,
    output logic             pop_vc0,
    output logic             pop_vc1,
    output logic             valid_out,
    output logic             sel_vc,
    output logic             dest_out,
    output logic [CNT_W-1:0] credit
);

    if (DATA_SIZE < 2 || WEIGHT0 < 1 || WEIGHT0 > (1 << CNT_W) - 1 ||
        WEIGHT1 < 1 || WEIGHT1 > (1 << CNT_W) - 1) begin : g_bad_param
        $error("vc_arbiter: illegal parameter set");
    end

    localparam logic [CNT_W-1:0] W0 = CNT_W'(WEIGHT0);
    localparam logic [CNT_W-1:0] W1 = CNT_W'(WEIGHT1);

    arb_state_e       state_q;
    logic             valid_q, sel_q, dest_q;
    logic             el0, el1, serving, pref_vc, el_pref, el_other;
    logic             gnt, gnt_vc, restart, clr, tc;
    logic [CNT_W-1:0] weight;

    assign el0 = active & ~empty_vc0 & ~(dest_vc0 ? pause_d1 : pause_d0);
    assign el1 = active & ~empty_vc1 & ~(dest_vc1 ? pause_d1 : pause_d0);

    assign serving  = (state_q == ST_SERVE0) || (state_q == ST_SERVE1);
    assign pref_vc  = (state_q == ST_SERVE1);
    assign el_pref  = pref_vc ? el1 : el0;
    assign el_other = pref_vc ? el0 : el1;

    // Preferred VC first, otherwise fall back to the other one (work-conserving).
    assign gnt     = ~reset & serving & (el_pref | el_other);
    assign gnt_vc  = el_pref ? pref_vc : ~pref_vc;
    assign restart = ~el_pref;
    assign clr     = ~serving | ~active;
    assign weight  = gnt_vc ? W1 : W0;

    assign pop_vc0 = gnt & ~gnt_vc;
    assign pop_vc1 = gnt & gnt_vc;

    wrr_credit #(
        .CNT_W(CNT_W)
    ) u_credit (
        .clk      (clk),
        .rst      (reset),
        .clr_i    (clr),
        .inc_i    (gnt),
        .restart_i(restart),
        .weight_i (weight),
        .credit_o (credit),
        .tc_o     (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            dest_q  <= 1'b0;
        end else begin
            valid_q <= gnt;
            if (gnt) begin
                sel_q  <= gnt_vc;
                dest_q <= gnt_vc ? dest_vc1 : dest_vc0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (active) state_q <= ST_SERVE0;
                end
                ST_SERVE0, ST_SERVE1: begin
                    if (!active) begin
                        state_q <= ST_IDLE;
                    end else if (gnt) begin
                        // Hitting the weight hands preference to the other VC.
                        state_q <= (gnt_vc ^ tc) ? ST_SERVE1 : ST_SERVE0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign valid_out = valid_q;
    assign sel_vc    = sel_q;
    assign dest_out  = dest_q;

endmodule
